// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - AHB-Lite encodings and loader state type shared by the SRAM loader
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ADDR,
        ST_DATA,
        ST_FIN
    } loader_state_t;

endpackage

// File: rtl/ahb_sram_loader_if.sv
// rtl/ahb_sram_loader_if.sv - AHB-Lite master/slave signal bundle between loader and SRAM slave
// master: drives HADDR/HTRANS/HWRITE/HSIZE/HBURST/HMASTLOCK/HWDATA, samples HREADY/HRESP
// slave:  the reverse direction
interface ahb_sram_loader_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
        input  HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
        output HREADY, HRESP
    );
endinterface

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs four accepted stream bytes little-endian into one 32-bit word
// clk/rst_n: clock, async active-low reset
// en: accept bytes (loader in COLLECT); clear: word consumed, restart at lane 0
// s_valid/s_data/s_ready: byte stream; word_valid/word: packed word, held until clear
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clear,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]      byte_idx;
    logic            full;
    logic [3:0][7:0] lanes;

    // Once four bytes are in, stop accepting until the loader takes the word.
    assign s_ready    = en && !full;
    assign word_valid = full;
    assign word       = lanes;

    // Lanes are not wiped on clear: the word stays readable while the bus
    // transfer that carries it is still in its address phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            full     <= 1'b0;
            lanes    <= '0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            full     <= 1'b0;
        end else if (s_valid && s_ready) begin
            lanes[byte_idx] <= s_data;
            byte_idx        <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_sram_loader.sv
// rtl/ahb_sram_loader.sv - AHB-Lite master filling SRAM from a byte stream, one SINGLE word write at a time
// HCLK/HRESETn: clock, async active-low reset
// start/start_addr/word_count: load request (taken only when idle)
// s_valid/s_data/s_ready: incoming image bytes
// bus: AHB-Lite master port
// busy/done/err/words_written: status back to the boot control logic
module ahb_sram_loader
    import ahb_lite_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 14
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 start,
    input  logic [31:0]          start_addr,
    input  logic [CNT_W-1:0]     word_count,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    output logic                 s_ready,
    ahb_sram_loader_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     words_written
);

    loader_state_t    state;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] ww_q;
    logic [1:0]       htrans_q;
    logic             hwrite_q;
    logic [31:0]      hwdata_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             pk_en;
    logic             pk_clear;
    logic             pk_word_valid;
    logic [31:0]      pk_word;

    assign pk_en    = (state == ST_COLLECT);
    assign pk_clear = (state == ST_COLLECT) && pk_word_valid;

    byte_packer u_packer (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .en         (pk_en),
        .clear      (pk_clear),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            ww_q     <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= {start_addr[31:2], 2'b00};
                        count_q <= word_count;
                        ww_q    <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (word_count == '0) begin
                            done_q <= 1'b1;
                            state  <= ST_FIN;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    // The cycle spent here with a full packer is the pipeline
                    // bubble between the fourth byte and the address phase.
                    if (pk_word_valid) begin
                        htrans_q <= HTRANS_NONSEQ;
                        hwrite_q <= 1'b1;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADY) begin
                        htrans_q <= HTRANS_IDLE;
                        hwrite_q <= 1'b0;
                        hwdata_q <= pk_word;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // HREADY low with HRESP high is the first error cycle: just wait.
                    if (bus.HREADY) begin
                        if (bus.HRESP) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= ST_FIN;
                        end else begin
                            ww_q   <= ww_q + CNT_W'(1);
                            addr_q <= {addr_q[31:ADDR_W], addr_q[ADDR_W-1:0] + ADDR_W'(4)};
                            if (ww_q + CNT_W'(1) == count_q) begin
                                done_q <= 1'b1;
                                state  <= ST_FIN;
                            end else begin
                                state <= ST_COLLECT;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.HADDR     = addr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = HSIZE_WORD;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = hwdata_q;

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = ww_q;

endmodule
